// File: rtl/gen_step_engine.sv
// Generation-update engine: walks the field in raster order, counts live neighbours from the
// current-field RAM and writes the B3/S23 result. Define GOL_TORUS_EN for a toroidal field.
module gen_step_engine #(
    parameter  int FIELD_W        = 30,
    parameter  int FIELD_H        = 50,
    localparam int NEIGHBOURS_CNT = 8,
    localparam int X_ADR_SIZE     = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE     = $clog2(FIELD_H)
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic                                        i_start,
    output logic                                        o_busy,
    output logic                                        o_done,
    output logic [15:0]                                 o_gen_cnt,
    output logic [X_ADR_SIZE-1:0]                       o_cell_x_adr,
    output logic [Y_ADR_SIZE-1:0]                       o_cell_y_adr,
    input  logic [NEIGHBOURS_CNT-1:0][X_ADR_SIZE-1:0]   i_nbrs_x_adr,
    input  logic [NEIGHBOURS_CNT-1:0][Y_ADR_SIZE-1:0]   i_nbrs_y_adr,
    input  logic [NEIGHBOURS_CNT-1:0]                   i_nbrs_rlvnt,
    output logic                                        o_rd_en,
    output logic [X_ADR_SIZE-1:0]                       o_rd_x_adr,
    output logic [Y_ADR_SIZE-1:0]                       o_rd_y_adr,
    input  logic                                        i_rd_data,
    output logic                                        o_wr_en,
    output logic [X_ADR_SIZE-1:0]                       o_wr_x_adr,
    output logic [Y_ADR_SIZE-1:0]                       o_wr_y_adr,
    output logic                                        o_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0]            SELF_SLOT = 4'd8;
    localparam logic [X_ADR_SIZE-1:0] X_LAST    = X_ADR_SIZE'(FIELD_W - 1);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST    = Y_ADR_SIZE'(FIELD_H - 1);

    state_t                 state_q, state_d;
    logic [X_ADR_SIZE-1:0]  cell_x_q, cell_x_d;
    logic [Y_ADR_SIZE-1:0]  cell_y_q, cell_y_d;
    logic [3:0]             slot_q, slot_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   self_q, self_d;
    logic                   nbr_rd_q, nbr_rd_d;
    logic                   self_rd_q, self_rd_d;
    logic [15:0]            gen_cnt_q, gen_cnt_d;

    logic [2:0]             slot_idx;
    logic [X_ADR_SIZE-1:0]  nbr_x;
    logic [Y_ADR_SIZE-1:0]  nbr_y;
    logic                   nbr_ok;
    logic                   rd_en;
    logic [X_ADR_SIZE-1:0]  rd_x;
    logic [Y_ADR_SIZE-1:0]  rd_y;

`ifdef GOL_TORUS_EN
    logic unused_rlvnt;
    assign unused_rlvnt = ^i_nbrs_rlvnt;
`endif

    // Read path is combinational: the neighbour generator answers for the current cell in the same cycle.
    always_comb begin
        slot_idx = slot_q[2:0];
        nbr_x    = i_nbrs_x_adr[slot_idx];
        nbr_y    = i_nbrs_y_adr[slot_idx];
`ifdef GOL_TORUS_EN
        if (int'(nbr_x) >= FIELD_W) nbr_x = (cell_x_q == '0) ? X_LAST : '0;
        if (int'(nbr_y) >= FIELD_H) nbr_y = (cell_y_q == '0) ? Y_LAST : '0;
        nbr_ok = 1'b1;
`else
        nbr_ok = i_nbrs_rlvnt[slot_idx];
`endif
        rd_en = 1'b0;
        rd_x  = '0;
        rd_y  = '0;
        if (state_q == S_READ) begin
            if (slot_q == SELF_SLOT) begin
                rd_en = 1'b1;
                rd_x  = cell_x_q;
                rd_y  = cell_y_q;
            end else if (nbr_ok) begin
                rd_en = 1'b1;
                rd_x  = nbr_x;
                rd_y  = nbr_y;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cell_x_d  = cell_x_q;
        cell_y_d  = cell_y_q;
        slot_d    = slot_q;
        cnt_d     = cnt_q;
        self_d    = self_q;
        gen_cnt_d = gen_cnt_q;
        nbr_rd_d  = rd_en && (slot_q != SELF_SLOT);
        self_rd_d = (state_q == S_READ) && (slot_q == SELF_SLOT);

        // RAM data lands one cycle after the strobe, so accumulate from last cycle's read flags.
        if (nbr_rd_q && i_rd_data) cnt_d = cnt_q + 4'd1;
        if (self_rd_q)             self_d = i_rd_data;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    cell_x_d = '0;
                    cell_y_d = '0;
                    slot_d   = '0;
                    cnt_d    = '0;
                    self_d   = 1'b0;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                if (slot_q == SELF_SLOT) state_d = S_DRAIN;
                else                     slot_d  = slot_q + 4'd1;
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                cnt_d  = '0;
                self_d = 1'b0;
                slot_d = '0;
                if (cell_x_q == X_LAST) begin
                    cell_x_d = '0;
                    if (cell_y_q == Y_LAST) begin
                        cell_y_d  = '0;
                        gen_cnt_d = gen_cnt_q + 16'd1;
                        state_d   = S_DONE;
                    end else begin
                        cell_y_d = cell_y_q + 1'b1;
                        state_d  = S_READ;
                    end
                end else begin
                    cell_x_d = cell_x_q + 1'b1;
                    state_d  = S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cell_x_q  <= '0;
            cell_y_q  <= '0;
            slot_q    <= '0;
            cnt_q     <= '0;
            self_q    <= 1'b0;
            nbr_rd_q  <= 1'b0;
            self_rd_q <= 1'b0;
            gen_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cell_x_q  <= cell_x_d;
            cell_y_q  <= cell_y_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            self_q    <= self_d;
            nbr_rd_q  <= nbr_rd_d;
            self_rd_q <= self_rd_d;
            gen_cnt_q <= gen_cnt_d;
        end
    end

    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_gen_cnt    = gen_cnt_q;
    assign o_cell_x_adr = cell_x_q;
    assign o_cell_y_adr = cell_y_q;
    assign o_rd_en      = rd_en;
    assign o_rd_x_adr   = rd_x;
    assign o_rd_y_adr   = rd_y;
    assign o_wr_en      = (state_q == S_WRITE);
    assign o_wr_x_adr   = cell_x_q;
    assign o_wr_y_adr   = cell_y_q;
    assign o_wr_data    = (state_q == S_WRITE) &&
                          ((cnt_q == 4'd3) || (self_q && (cnt_q == 4'd2)));

endmodule

// File: tb/tb_gen_step_engine.sv
// Bench for gen_step_engine: a 4x3 and a 5x5 instance with RAM and neighbour-generator models,
// checked against a Life reference; honours GOL_TORUS_EN the same way the design does.
module tb_gen_step_engine;
    localparam int AW  = 4, AH = 3, BW = 5, BH = 5;
    localparam int AXS = $clog2(AW), AYS = $clog2(AH), BXS = $clog2(BW), BYS = $clog2(BH);

    typedef struct { int idx; bit d; int cyc; } wr_t;
    typedef struct { bit en; int x; int y; } rd_t;
    typedef struct { logic [24:0] field; logic [24:0] want; string name; } vec_t;

    logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
    int   cyc = 0;
    int   total = 0, bad = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A (4x3)
    logic busy_a, done_a, rd_en_a, rd_d_a, wr_en_a, wr_d_a;
    logic [15:0] gen_a;
    logic [AXS-1:0] cx_a, rd_x_a, wr_x_a;
    logic [AYS-1:0] cy_a, rd_y_a, wr_y_a;
    logic [7:0][AXS-1:0] nx_a;
    logic [7:0][AYS-1:0] ny_a;
    logic [7:0] rl_a;
    logic [AW*AH-1:0] cur_a = '0;
    wr_t wr_q_a[$];

    // instance B (5x5)
    logic busy_b, done_b, rd_en_b, rd_d_b, wr_en_b, wr_d_b;
    logic [15:0] gen_b;
    logic [BXS-1:0] cx_b, rd_x_b, wr_x_b;
    logic [BYS-1:0] cy_b, rd_y_b, wr_y_b;
    logic [7:0][BXS-1:0] nx_b;
    logic [7:0][BYS-1:0] ny_b;
    logic [7:0] rl_b;
    logic [BW*BH-1:0] cur_b = '0;
    wr_t wr_q_b[$];
    rd_t rd_log_b[1024];

    gen_step_engine #(.FIELD_W(AW), .FIELD_H(AH)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
        .o_gen_cnt(gen_a), .o_cell_x_adr(cx_a), .o_cell_y_adr(cy_a),
        .i_nbrs_x_adr(nx_a), .i_nbrs_y_adr(ny_a), .i_nbrs_rlvnt(rl_a),
        .o_rd_en(rd_en_a), .o_rd_x_adr(rd_x_a), .o_rd_y_adr(rd_y_a), .i_rd_data(rd_d_a),
        .o_wr_en(wr_en_a), .o_wr_x_adr(wr_x_a), .o_wr_y_adr(wr_y_a), .o_wr_data(wr_d_a)
    );

    gen_step_engine #(.FIELD_W(BW), .FIELD_H(BH)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
        .o_gen_cnt(gen_b), .o_cell_x_adr(cx_b), .o_cell_y_adr(cy_b),
        .i_nbrs_x_adr(nx_b), .i_nbrs_y_adr(ny_b), .i_nbrs_rlvnt(rl_b),
        .o_rd_en(rd_en_b), .o_rd_x_adr(rd_x_b), .o_rd_y_adr(rd_y_b), .i_rd_data(rd_d_b),
        .o_wr_en(wr_en_b), .o_wr_x_adr(wr_x_b), .o_wr_y_adr(wr_y_b), .o_wr_data(wr_d_b)
    );

    // Slot layout: 0..2 row above (left to right), 3 left, 4 right, 5..7 row below.
    function automatic int dx_of(input int k);
        case (k)
            0, 3, 5: return -1;
            1, 6:    return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int dy_of(input int k);
        return (k < 3) ? -1 : ((k < 5) ? 0 : 1);
    endfunction

    function automatic bit in_field(input int x, input int y, input int w, input int h);
        return (x >= 0) && (x < w) && (y >= 0) && (y < h);
    endfunction

    // Raw neighbour coordinates truncated to the port width (so -1 and W appear as wrapped codes).
    always_comb begin
        nx_a = '0; ny_a = '0; rl_a = '0;
        nx_b = '0; ny_b = '0; rl_b = '0;
        for (int k = 0; k < 8; k++) begin
            nx_a[k] = AXS'(int'(cx_a) + dx_of(k));
            ny_a[k] = AYS'(int'(cy_a) + dy_of(k));
            rl_a[k] = in_field(int'(cx_a) + dx_of(k), int'(cy_a) + dy_of(k), AW, AH);
            nx_b[k] = BXS'(int'(cx_b) + dx_of(k));
            ny_b[k] = BYS'(int'(cy_b) + dy_of(k));
            rl_b[k] = in_field(int'(cx_b) + dx_of(k), int'(cy_b) + dy_of(k), BW, BH);
        end
    end

    // Sync-read RAMs; idle cycles return random junk so stray accumulation shows up.
    always @(posedge clk) begin
        rd_d_a <= rd_en_a ? cur_a[int'(rd_y_a) * AW + int'(rd_x_a)] : 1'($urandom);
        rd_d_b <= rd_en_b ? cur_b[int'(rd_y_b) * BW + int'(rd_x_b)] : 1'($urandom);
        rd_log_b[cyc % 1024] <= '{rd_en_b, int'(rd_x_b), int'(rd_y_b)};
        if (wr_en_a) wr_q_a.push_back('{int'(wr_y_a) * AW + int'(wr_x_a), wr_d_a, cyc});
        if (wr_en_b) wr_q_b.push_back('{int'(wr_y_b) * BW + int'(wr_x_b), wr_d_b, cyc});
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] life_ref(input logic [63:0] f, input int w, input int h);
        logic [63:0] r;
        int n, px, py;
        r = '0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        px = x + dx;
                        py = y + dy;
`ifdef GOL_TORUS_EN
                        px = (px + w) % w;
                        py = (py + h) % h;
`endif
                        if ((dx != 0 || dy != 0) && in_field(px, py, w, h))
                            n += int'(f[py * w + px]);
                    end
                end
                r[y * w + x] = (n == 3) || (f[y * w + x] && n == 2);
            end
        end
        return r;
    endfunction

    // Starts a generation, optionally re-pulses start at relative cycle extra_rel, waits for done.
    task automatic run_gen(input bit use_b, input int cells, input int extra_rel,
                           output int t0, output int done_rel, output int busy_n);
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        t0 = cyc;
        done_rel = -1;
        busy_n = 0;
        for (int i = 0; i < 11 * cells + 40; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (cyc - t0 == extra_rel) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end
            busy_n += int'(use_b ? busy_b : busy_a);
            if (use_b ? done_b : done_a) begin
                done_rel = cyc - t0;
                break;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_run(input string tag, input bit use_b, input int cells, input int t0,
                             input int done_rel, input int busy_n, input int wr_off,
                             input logic [63:0] want, input int gen_exp);
        int n, bad_order;
        logic [63:0] got, mask;
        wr_t e;
        n = (use_b ? wr_q_b.size() : wr_q_a.size()) - wr_off;
        got = '1;
        bad_order = 0;
        for (int i = 0; i < n; i++) begin
            if (use_b) e = wr_q_b[wr_off + i]; else e = wr_q_a[wr_off + i];
            if (e.idx != i || e.cyc - t0 != 11 * (i + 1)) bad_order++;
            if (e.idx >= 0 && e.idx < 64) got[e.idx] = e.d;
        end
        mask = (64'd1 << cells) - 64'd1;
        check({tag, "_done_cycle"}, done_rel, 11 * cells + 1);
        check({tag, "_busy_cycles"}, busy_n, 11 * cells + 1);
        check({tag, "_wr_count"}, n, cells);
        check({tag, "_wr_order"}, bad_order, 0);
        check({tag, "_field"}, got & mask, want & mask);
        check({tag, "_gen_cnt"}, use_b ? gen_b : gen_a, 16'(gen_exp));
        check({tag, "_idle_busy"}, use_b ? busy_b : busy_a, 0);
    endtask

    task automatic check_reads(input string tag, input int t0, input int cx, input int cy,
                               input int want_n);
        int n, c;
        bit en_exp;
        rd_t e;
        n = 0;
        c = cy * BW + cx;
        for (int k = 0; k < 9; k++) begin
            e = rd_log_b[(t0 + 1 + 11 * c + k) % 1024];
`ifdef GOL_TORUS_EN
            en_exp = 1'b1;
`else
            en_exp = (k == 8) || in_field(cx + dx_of(k), cy + dy_of(k), BW, BH);
`endif
            n += int'(e.en);
            check($sformatf("%s_en_slot%0d", tag, k), e.en, en_exp);
            if (e.en && en_exp) begin
                check($sformatf("%s_x_slot%0d", tag, k), e.x,
                      (k == 8) ? cx : (cx + dx_of(k) + BW) % BW);
                check($sformatf("%s_y_slot%0d", tag, k), e.y,
                      (k == 8) ? cy : (cy + dy_of(k) + BH) % BH);
            end
        end
        check({tag, "_read_count"}, n, want_n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int t0, done_rel, busy_n, off, gen_exp_a, gen_exp_b, n0;
        logic [63:0] want;

        vecs[0] = '{25'h0003800, 25'h0021080, "blinker_h"};
        vecs[1] = '{25'h0021080, 25'h0003800, "blinker_v"};
        vecs[2] = '{25'h00018C0, 25'h00018C0, "block"};
        vecs[3] = '{25'h0001000, 25'h0000000, "single"};
        vecs[4] = '{25'h0000000, 25'h0000000, "empty"};
`ifdef GOL_TORUS_EN
        vecs[5] = '{25'h0100011, 25'h1100011, "corners"};
`else
        vecs[5] = '{25'h0100011, 25'h0000000, "corners"};
`endif
        gen_exp_a = 0;
        gen_exp_b = 0;

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {busy_a, busy_b}, 0);
        check("rst_done", {done_a, done_b}, 0);
        check("rst_gen", {gen_a, gen_b}, 0);
        check("rst_strobes", {rd_en_a, wr_en_a, rd_en_b, wr_en_b}, 0);
        check("rst_adr", {cx_a, cy_a, rd_x_a, rd_y_a, wr_x_a, wr_y_a, wr_d_a,
                          cx_b, cy_b, rd_x_b, rd_y_b, wr_x_b, wr_y_b, wr_d_b}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_rd", {rd_en_a, rd_en_b, wr_en_a, wr_en_b}, 0);

        // all-dead 4x3
        cur_a = '0;
        off = wr_q_a.size();
        run_gen(1'b0, AW * AH, -1, t0, done_rel, busy_n);
        gen_exp_a++;
        check_run("dead4x3", 1'b0, AW * AH, t0, done_rel, busy_n, off, 64'd0, gen_exp_a);

        // vector table on 5x5
        for (int v = 0; v < 6; v++) begin
            cur_b = vecs[v].field;
            off = wr_q_b.size();
            run_gen(1'b1, BW * BH, -1, t0, done_rel, busy_n);
            gen_exp_b++;
            check_run(vecs[v].name, 1'b1, BW * BH, t0, done_rel, busy_n, off,
                      64'(vecs[v].want), gen_exp_b);
            if (v == 0) begin
`ifdef GOL_TORUS_EN
                check_reads("rd_00", t0, 0, 0, 9);
                check_reads("rd_44", t0, 4, 4, 9);
`else
                check_reads("rd_00", t0, 0, 0, 4);
                check_reads("rd_44", t0, 4, 4, 4);
`endif
            end
        end

        // random fields against the reference model
        for (int r = 0; r < 3; r++) begin
            cur_a = (AW * AH)'($urandom);
            off = wr_q_a.size();
            run_gen(1'b0, AW * AH, -1, t0, done_rel, busy_n);
            gen_exp_a++;
            check_run($sformatf("rand_a%0d", r), 1'b0, AW * AH, t0, done_rel, busy_n, off,
                      life_ref(64'(cur_a), AW, AH), gen_exp_a);
            cur_b = (BW * BH)'($urandom);
            off = wr_q_b.size();
            run_gen(1'b1, BW * BH, -1, t0, done_rel, busy_n);
            gen_exp_b++;
            check_run($sformatf("rand_b%0d", r), 1'b1, BW * BH, t0, done_rel, busy_n, off,
                      life_ref(64'(cur_b), BW, BH), gen_exp_b);
        end

        // start re-pulsed mid-run must be ignored
        cur_b = (BW * BH)'($urandom);
        off = wr_q_b.size();
        run_gen(1'b1, BW * BH, 5, t0, done_rel, busy_n);
        gen_exp_b++;
        want = life_ref(64'(cur_b), BW, BH);
        check_run("restart_ignored", 1'b1, BW * BH, t0, done_rel, busy_n, off, want, gen_exp_b);
        repeat (15) @(negedge clk);
        check("restart_no_rerun", wr_q_b.size() - off, BW * BH);

        // reset in the middle of a generation
        off = wr_q_b.size();
        @(negedge clk);
        start_b = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_b = 1'b0;
        while (cyc - t0 < 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cycle", cyc - t0, 21);
        check("midrst_busy", busy_b, 0);
        check("midrst_gen", gen_b, 0);
        check("midrst_strobes", {rd_en_b, wr_en_b, done_b}, 0);
        n0 = wr_q_b.size();
        check("midrst_writes_before", n0 - off, 1);
        repeat (40) @(negedge clk);
        check("midrst_writes_after", wr_q_b.size() - n0, 0);
        check("midrst_still_idle", {busy_b, rd_en_b}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gen_step_engine.md
Name: gen_step_engine

Overview:
Sequential generation-update engine for the Game of Life field. It walks every cell in raster order and drives the cell coordinate into the combinational neighbour-address generator. It reads the current-generation field RAM once per relevant neighbour plus once for the cell itself, applies rule B3/S23, and writes the result into the next-generation field RAM. Sits between the field-buffer pair and the top-level generation sequencer.

Parameters:
FIELD_W, 30, field width in cells; X_ADR_SIZE = $clog2(FIELD_W)
FIELD_H, 50, field height in cells; Y_ADR_SIZE = $clog2(FIELD_H)
NEIGHBOURS_CNT, 8, neighbour slots; localparam, fixed

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_start  input  1  one-cycle pulse: compute one generation
o_busy  output  1  high from the cycle after start is accepted until o_done
o_done  output  1  one-cycle pulse after the last write
o_gen_cnt  output  16  completed-generation counter
o_cell_x_adr  output  X_ADR_SIZE  current cell x, to neighbour-address generator
o_cell_y_adr  output  Y_ADR_SIZE  current cell y, to neighbour-address generator
i_nbrs_x_adr  input  X_ADR_SIZE x8 array  neighbour x coordinates (slots 0..7)
i_nbrs_y_adr  input  Y_ADR_SIZE x8 array  neighbour y coordinates
i_nbrs_rlvnt  input  1 x8 array  neighbour lies inside the field
o_rd_en  output  1  current-field read strobe
o_rd_x_adr  output  X_ADR_SIZE  read x
o_rd_y_adr  output  Y_ADR_SIZE  read y
i_rd_data  input  1  cell state; valid the cycle after o_rd_en (sync RAM)
o_wr_en  output  1  next-field write strobe
o_wr_x_adr  output  X_ADR_SIZE  write x
o_wr_y_adr  output  Y_ADR_SIZE  write y
o_wr_data  output  1  next cell state

Behaviour:
- Reset: state IDLE. Cell counters, o_busy, o_done, o_rd_en, o_wr_en, o_gen_cnt and all address/data outputs are 0.
- FSM states: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE: i_start=1 loads cell (0,0) and slot k=0, then moves to READ. i_start is ignored in every other state.
- READ: runs 9 cycles, k=0..8. For k<8, o_rd_en = i_nbrs_rlvnt[k] and the read address is the slot-k neighbour. For k=8, o_rd_en=1 and the read address is the cell itself. Irrelevant slots issue no read and count as 0.
- Accumulation: each cycle, a 4-bit counter adds i_rd_data if the previous cycle issued a neighbour read. The self bit is captured one cycle after k=8.
- DRAIN: one cycle that absorbs the self-read data.
- WRITE: one cycle with o_wr_en=1 at the cell address and o_wr_data = (cnt==3) | (self & cnt==2). The counter then clears.
- Next cell: x increments; after x=FIELD_W-1, x returns to 0 and y increments. After cell (FIELD_W-1, FIELD_H-1) the FSM goes to DONE, otherwise back to READ with k=0.
- DONE: one cycle with o_done=1 and o_gen_cnt incremented (wraps at 2^16), then IDLE.
- Timing: 11 cycles per cell. If start is sampled in cycle 0, READ begins in cycle 1 and o_done=1 in cycle 11*FIELD_W*FIELD_H+1.
- o_busy is 1 in READ, DRAIN, WRITE and DONE.
- o_cell_*_adr always show the cell being processed; the neighbour generator is combinational, so its inputs are used in the same cycle.
- Reset mid-operation: next cycle is IDLE with all outputs at their reset values. No further reads or writes occur, and o_gen_cnt clears.
- No reads or writes are issued in IDLE.

Optional Feature:
GOL_TORUS_EN:
- Defined: toroidal field. i_nbrs_rlvnt is ignored and all 8 slots are read.
- Per slot, if the neighbour x is >= FIELD_W, substitute (cell_x==0 ? FIELD_W-1 : 0). The same rule applies to y with FIELD_H.
- This is correct for both power-of-two and non-power-of-two sizes.
- Undefined: bounded field; out-of-field neighbours count as dead, as described above.

Test Plan:
1. Reset, with W=4, H=3: assert i_rst for 2 cycles -> all outputs 0, o_gen_cnt=0, no rd/wr strobes.
2. All-dead 4x3 field, pulse i_start -> 12 writes of 0 in raster order, one every 11 cycles; o_done in cycle 133; o_gen_cnt=1.
3. 5x5 blinker with cells (1,2),(2,2),(3,2) alive, one generation -> written field has exactly (2,1),(2,2),(2,3) alive; a second run restores the horizontal blinker and o_gen_cnt=2.
4. Corner cell (0,0) -> during its READ only slots 4, 6, 7 and self assert o_rd_en (4 reads total); cell (4,4) in 5x5 -> only slots 0, 1, 3 and self.
5. Pulse i_start again at cycle 5 of a run -> ignored, total write count unchanged. Assert i_rst at cycle 20 -> o_busy=0 at cycle 21, zero writes afterwards.
6. GOL_TORUS_EN defined, 5x5 field with (0,0),(4,0),(0,4) alive -> (4,4) written 1. Same stimulus without the macro -> (4,4) written 0.
